// File: rtl/i2s_audio_path.sv
// I2S slave transceiver: deserialises codec ADC frames, applies channel mode and
// attenuation, reserialises to the DAC and tracks per-channel decaying peak levels.
module i2s_audio_path #(
   parameter int DATA_WIDTH   = 24,
   parameter int DECAY_FRAMES = 1024
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic                         AUD_BCLK,
   input  logic                         AUD_ADCLRCK,
   input  logic                         AUD_DACLRCK,
   input  logic                         AUD_ADCDAT,
   output logic                         AUD_DACDAT,
   input  logic [1:0]                   mode,
   input  logic [2:0]                   gain,
   output logic                         frame_valid,
   output logic signed [DATA_WIDTH-1:0] rx_left,
   output logic signed [DATA_WIDTH-1:0] rx_right,
   output logic [7:0]                   peak_l,
   output logic [7:0]                   peak_r,
   output logic                         frame_err
);

   localparam logic [5:0] DW_CNT = 6'(DATA_WIDTH);
   localparam int FCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(DECAY_FRAMES - 1);

   // Sum carries one extra bit so full-scale inputs cannot wrap before halving.
   function automatic logic signed [DATA_WIDTH-1:0] mono_mix(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b);
      logic signed [DATA_WIDTH:0] sum;
      sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      return sum[DATA_WIDTH:1];
   endfunction

   function automatic logic [7:0] peak_mag(input logic signed [DATA_WIDTH-1:0] s);
      logic [8:0] top;
      logic [8:0] mag;
      top = s[DATA_WIDTH-1 -: 9];
      mag = top[8] ? (~top + 9'd1) : top;
      return mag[8] ? 8'hFF : mag[7:0];
   endfunction

   function automatic logic [7:0] peak_next(input logic [7:0] cur, input logic [7:0] mag,
                                           input logic wrap);
      if (mag > cur)
         return mag;
      else if (wrap && (cur != 8'd0))
         return cur - 8'd1;
      else
         return cur;
   endfunction

   logic [1:0] bclk_sync, adclr_sync, daclr_sync, adcdat_sync;
   logic       bclk_d;
   logic       bclk_rise, bclk_fall;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         bclk_sync   <= '0;
         adclr_sync  <= '0;
         daclr_sync  <= '0;
         adcdat_sync <= '0;
         bclk_d      <= 1'b0;
      end else begin
         bclk_sync   <= {bclk_sync[0], AUD_BCLK};
         adclr_sync  <= {adclr_sync[0], AUD_ADCLRCK};
         daclr_sync  <= {daclr_sync[0], AUD_DACLRCK};
         adcdat_sync <= {adcdat_sync[0], AUD_ADCDAT};
         bclk_d      <= bclk_sync[1];
      end
   end

   assign bclk_rise = bclk_sync[1] & ~bclk_d;
   assign bclk_fall = ~bclk_sync[1] & bclk_d;

   // ---- receive: bit-level capture on BCLK rising edges ----
   logic                         rx_lr_q, rx_sync_q;
   logic [5:0]                   rx_cnt, rx_inc;
   logic [DATA_WIDTH-2:0]        rx_shift;
   logic signed [DATA_WIDTH-1:0] hold_l, hold_r;
   logic                         have_l, have_r;
   logic                         rx_edge, frame_done;

   assign rx_inc     = (rx_cnt == 6'd63) ? rx_cnt : rx_cnt + 6'd1;
   assign rx_edge    = bclk_rise & (adclr_sync[1] != rx_lr_q);
   assign frame_done = rx_edge & rx_lr_q & ~adclr_sync[1] & rx_sync_q & have_l & have_r;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         rx_lr_q   <= 1'b0;
         rx_sync_q <= 1'b0;
         rx_cnt    <= '0;
         rx_shift  <= '0;
         hold_l    <= '0;
         hold_r    <= '0;
         have_l    <= 1'b0;
         have_r    <= 1'b0;
         frame_err <= 1'b0;
      end else if (bclk_rise) begin
         if (rx_edge) begin
            rx_lr_q   <= adclr_sync[1];
            rx_sync_q <= 1'b1;
            rx_cnt    <= '0;
            if ((rx_cnt != 6'd0) && (rx_cnt < DW_CNT))
               frame_err <= 1'b1;
         end else if (rx_sync_q) begin
            // Counting starts only after the first boundary, so a slot joined mid-way is never captured.
            rx_cnt <= rx_inc;
            if (rx_inc <= DW_CNT)
               rx_shift <= {rx_shift[DATA_WIDTH-3:0], adcdat_sync[1]};
            if (rx_inc == DW_CNT) begin
               if (rx_lr_q) begin
                  hold_r <= {rx_shift, adcdat_sync[1]};
                  have_r <= 1'b1;
               end else begin
                  hold_l <= {rx_shift, adcdat_sync[1]};
                  have_l <= 1'b1;
               end
            end
         end
      end
   end

   // ---- p0: frame register, control sampled with the frame ----
   logic [1:0] mode_p0;
   logic [2:0] gain_p0;
   logic       vld_p0;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         rx_left  <= '0;
         rx_right <= '0;
         mode_p0  <= '0;
         gain_p0  <= '0;
         vld_p0   <= 1'b0;
      end else begin
         vld_p0 <= frame_done;
         if (frame_done) begin
            rx_left  <= hold_l;
            rx_right <= hold_r;
            mode_p0  <= mode;
            gain_p0  <= gain;
         end
      end
   end

   assign frame_valid = vld_p0;

   logic signed [DATA_WIDTH-1:0] sel_l, sel_r;

   always_comb begin
      sel_l = rx_left;
      sel_r = rx_right;
      case (mode_p0)
         2'd1: begin
            sel_l = rx_right;
            sel_r = rx_left;
         end
         2'd2: begin
            sel_l = mono_mix(rx_left, rx_right);
            sel_r = sel_l;
         end
         2'd3: begin
            sel_l = '0;
            sel_r = '0;
         end
         default: ;
      endcase
   end

   // ---- p1: processed pair and peak meters ----
   logic signed [DATA_WIDTH-1:0] proc_l_p1, proc_r_p1;
   logic [FCW-1:0]               frame_cnt;
   logic                         decay_wrap;

   assign decay_wrap = (frame_cnt == FRAME_LAST);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         proc_l_p1 <= '0;
         proc_r_p1 <= '0;
         frame_cnt <= '0;
         peak_l    <= '0;
         peak_r    <= '0;
      end else if (vld_p0) begin
         proc_l_p1 <= sel_l >>> gain_p0;
         proc_r_p1 <= sel_r >>> gain_p0;
         frame_cnt <= decay_wrap ? '0 : frame_cnt + 1'b1;
         peak_l    <= peak_next(peak_l, peak_mag(rx_left), decay_wrap);
         peak_r    <= peak_next(peak_r, peak_mag(rx_right), decay_wrap);
      end
   end

   // ---- transmit: serialiser on BCLK falling edges ----
   logic                  tx_lr_q;
   logic [5:0]            tx_cnt, tx_inc;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] shadow_r;

   assign tx_inc = (tx_cnt == 6'd63) ? tx_cnt : tx_cnt + 6'd1;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         tx_lr_q    <= 1'b0;
         tx_cnt     <= '0;
         tx_shift   <= '0;
         shadow_r   <= '0;
         AUD_DACDAT <= 1'b0;
      end else if (bclk_fall) begin
         if (daclr_sync[1] != tx_lr_q) begin
            tx_lr_q    <= daclr_sync[1];
            tx_cnt     <= '0;
            AUD_DACDAT <= 1'b0;
            // A falling LRCK starts a frame: the left word goes straight into the shifter.
            if (daclr_sync[1]) begin
               tx_shift <= shadow_r;
            end else begin
               tx_shift <= proc_l_p1;
               shadow_r <= proc_r_p1;
            end
         end else begin
            tx_cnt <= tx_inc;
            if (tx_inc <= DW_CNT) begin
               AUD_DACDAT <= tx_shift[DATA_WIDTH-1];
               tx_shift   <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end else begin
               AUD_DACDAT <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_path.sv
// Bench for i2s_audio_path: a codec-master model drives random and directed slots
// and a slot-level reference model predicts captures, DAC bits and peak levels.
module tb_i2s_audio_path;

   localparam int DW = 24;
   localparam int DF = 4;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b1;
   logic          AUD_BCLK = 1'b0;
   logic          AUD_ADCLRCK = 1'b0;
   logic          AUD_DACLRCK = 1'b0;
   logic          AUD_ADCDAT = 1'b0;
   logic          AUD_DACDAT;
   logic [1:0]    mode = 2'd0;
   logic [2:0]    gain = 3'd0;
   logic          frame_valid;
   logic [DW-1:0] rx_left, rx_right;
   logic [7:0]    peak_l, peak_r;
   logic          frame_err;

   int errors = 0;
   int checks = 0;
   int fv_seen = 0;

   // reference model state
   logic          m_prev = 1'b0;
   bit            m_sync = 0;
   bit            m_have_l = 0, m_have_r = 0;
   logic [DW-1:0] m_hold_l = '0, m_hold_r = '0;
   logic [DW-1:0] m_rx_l = '0, m_rx_r = '0;
   logic [DW-1:0] m_proc_l = '0, m_proc_r = '0;
   logic [DW-1:0] m_dac_l = '0, m_dac_r = '0;
   bit            m_err = 0;
   int            m_cnt = 0;
   int            m_fv = 0;
   int            m_peak_l = 0, m_peak_r = 0;
   int            m_fcnt = 0;

   i2s_audio_path #(.DATA_WIDTH(DW), .DECAY_FRAMES(DF)) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_ADCLRCK (AUD_ADCLRCK),
      .AUD_DACLRCK (AUD_DACLRCK),
      .AUD_ADCDAT  (AUD_ADCDAT),
      .AUD_DACDAT  (AUD_DACDAT),
      .mode        (mode),
      .gain        (gain),
      .frame_valid (frame_valid),
      .rx_left     (rx_left),
      .rx_right    (rx_right),
      .peak_l      (peak_l),
      .peak_r      (peak_r),
      .frame_err   (frame_err)
   );

   always #10 CLOCK = ~CLOCK;

   always @(negedge CLOCK)
      if (frame_valid !== 1'b0) fv_seen++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sx(input logic [DW-1:0] v);
      return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
   endfunction

   function automatic int mag8(input int v);
      int t;
      t = v >>> (DW - 9);
      if (t < 0) t = -t;
      if (t > 255) t = 255;
      return t;
   endfunction

   function automatic int peak_upd(input int cur, input int mag, input bit wrap);
      if (mag > cur) return mag;
      if (wrap && cur > 0) return cur - 1;
      return cur;
   endfunction

   task automatic model_frame();
      int l, r, ol, orr;
      bit wrap;
      m_rx_l = m_hold_l;
      m_rx_r = m_hold_r;
      m_fv++;
      l = sx(m_rx_l);
      r = sx(m_rx_r);
      case (mode)
         2'd0: begin ol = l; orr = r; end
         2'd1: begin ol = r; orr = l; end
         2'd2: begin ol = (l + r) >>> 1; orr = ol; end
         default: begin ol = 0; orr = 0; end
      endcase
      ol  = ol >>> gain;
      orr = orr >>> gain;
      m_proc_l = ol[DW-1:0];
      m_proc_r = orr[DW-1:0];
      wrap = (m_fcnt == DF - 1);
      m_fcnt = wrap ? 0 : m_fcnt + 1;
      m_peak_l = peak_upd(m_peak_l, mag8(l), wrap);
      m_peak_r = peak_upd(m_peak_r, mag8(r), wrap);
   endtask

   task automatic check_zero_outputs(input string pfx);
      check_eq({pfx, " dacdat"}, 32'(AUD_DACDAT), 32'd0);
      check_eq({pfx, " frame_valid"}, 32'(frame_valid), 32'd0);
      check_eq({pfx, " rx_left"}, 32'(rx_left), 32'd0);
      check_eq({pfx, " rx_right"}, 32'(rx_right), 32'd0);
      check_eq({pfx, " peak_l"}, 32'(peak_l), 32'd0);
      check_eq({pfx, " peak_r"}, 32'(peak_r), 32'd0);
      check_eq({pfx, " frame_err"}, 32'(frame_err), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLOCK);
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK);
      check_zero_outputs("midreset");
      RESET = 1'b0;
      m_prev = 1'b0; m_sync = 0; m_have_l = 0; m_have_r = 0;
      m_hold_l = '0; m_hold_r = '0; m_rx_l = '0; m_rx_r = '0;
      m_proc_l = '0; m_proc_r = '0; m_dac_l = '0; m_dac_r = '0;
      m_err = 0; m_cnt = 0; m_peak_l = 0; m_peak_r = 0; m_fcnt = 0;
   endtask

   // One LR slot of len BCLK periods; the codec changes LRCK/data on BCLK falling edges.
   task automatic slot(input logic ch, input logic [DW-1:0] word, input int len, input int rst_at);
      logic [31:0]   cap, expc;
      logic [DW-1:0] wsh, dsh;
      logic          ab, eb;
      bit            did_rst;
      cap = '0; expc = '0; did_rst = 0;
      if (ch != m_prev) begin
         if (m_sync && m_cnt >= 1 && m_cnt < DW) m_err = 1;
         if (m_prev == 1'b1) begin
            m_dac_l = m_proc_l;
            m_dac_r = m_proc_r;
            if (m_sync && m_have_l && m_have_r) model_frame();
         end
         m_prev = ch;
         m_sync = 1;
      end
      wsh = word;
      dsh = ch ? m_dac_r : m_dac_l;
      for (int k = 0; k < len; k++) begin
         if (k >= 1 && k <= DW) begin
            ab = wsh[DW-1]; wsh = wsh << 1;
            eb = dsh[DW-1]; dsh = dsh << 1;
         end else begin
            ab = 1'($urandom);
            eb = 1'b0;
         end
         AUD_BCLK = 1'b0;
         AUD_ADCLRCK = ch;
         AUD_DACLRCK = ch;
         AUD_ADCDAT = ab;
         if (k == rst_at) begin
            do_reset();
            did_rst = 1;
            repeat (5) @(negedge CLOCK);
         end else begin
            repeat (8) @(negedge CLOCK);
         end
         AUD_BCLK = 1'b1;
         cap  = {cap[30:0], AUD_DACDAT};
         expc = {expc[30:0], eb};
         repeat (8) @(negedge CLOCK);
         if (k == 0) begin
            check_eq("frame_valid count", 32'(fv_seen), 32'(m_fv));
            check_eq("rx_left", 32'(rx_left), 32'(m_rx_l));
            check_eq("rx_right", 32'(rx_right), 32'(m_rx_r));
            check_eq("frame_err", 32'(frame_err), 32'(m_err));
            check_eq("peak_l", 32'(peak_l), 32'(m_peak_l));
            check_eq("peak_r", 32'(peak_r), 32'(m_peak_r));
         end
      end
      if (m_sync && len >= DW + 1) begin
         if (ch) begin m_hold_r = word; m_have_r = 1; end
         else    begin m_hold_l = word; m_have_l = 1; end
      end
      m_cnt = m_sync ? ((len - 1 > 63) ? 63 : len - 1) : 0;
      if (!did_rst) check_eq(ch ? "dac right slot" : "dac left slot", cap, expc);
   endtask

   task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      slot(1'b0, l, 32, -1);
      slot(1'b1, r, 32, -1);
   endtask

   initial begin
      RESET = 1'b1;
      repeat (4) @(negedge CLOCK);
      check_zero_outputs("reset");
      RESET = 1'b0;
      repeat (2) @(negedge CLOCK);

      // startup: partial tracking, no frame before a full pair
      frame(DW'($urandom), DW'($urandom));
      frame(DW'($urandom), DW'($urandom));

      // pass-through
      mode = 2'd0; gain = 3'd0;
      repeat (3) frame(24'h123456, 24'hFEDCBA);

      // swap
      mode = 2'd1;
      repeat (3) frame(24'h123456, 24'hFEDCBA);

      // mute selected mid-frame
      slot(1'b0, 24'h123456, 32, -1);
      mode = 2'd3;
      slot(1'b1, 24'hFEDCBA, 32, -1);
      repeat (2) frame(24'h123456, 24'hFEDCBA);

      // mono mix and attenuation
      mode = 2'd2; gain = 3'd0;
      frame(24'h7FFFFF, 24'h7FFFFF);
      frame(24'h800000, 24'h7FFFFF);
      gain = 3'd3;
      frame(24'h000010, 24'h000010);
      frame(24'hFFFFFF, 24'hFFFFFF);
      frame(24'h000000, 24'h000000);

      // random modes, gains and samples
      for (int i = 0; i < 4; i++) begin
         mode = 2'($urandom);
         gain = 3'($urandom);
         frame(DW'($urandom), DW'($urandom));
      end

      // short right slot
      mode = 2'd0; gain = 3'd0;
      frame(24'h0A0B0C, 24'h112233);
      slot(1'b0, 24'h445566, 32, -1);
      slot(1'b1, 24'h778899, 12, -1);
      frame(24'h13579B, 24'h2468AC);
      frame(DW'($urandom), DW'($urandom));

      // reset during bit 10 of a left slot, then peak meter decay
      slot(1'b0, DW'($urandom), 32, 10);
      slot(1'b1, 24'h000000, 32, -1);
      frame(24'h400000, 24'h000000);
      repeat (9) frame(24'h000000, 24'h000000);
      frame(24'h800000, 24'h000000);
      frame(24'h000000, 24'h000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
